div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Issue/sequencing stage in front of div32, the multi-cycle divider with a start/done handshake.
- Accepts RV32M divide ops (DIV, DIVU, REM, REMU) from the execute stage over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow itself without starting div32; otherwise drives div32 and returns the selected quotient or remainder with its rd tag.
- Provides the stall signal to the pipeline and a flush path.

Parameters:
- XLEN, 32, operand/result width; must match div32.
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  op offered
- req_ready  out  1  op accepted when req_valid & req_ready
- req_funct3  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes treated as DIVU
- req_rs1  in  XLEN  dividend
- req_rs2  in  XLEN  divisor
- req_tag  in  TAG_W  rd address
- flush  in  1  kill any accepted, unreturned op
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_data  out  XLEN  result
- rsp_tag  out  TAG_W  rd of result
- busy  out  1  high in any state but IDLE (pipeline stall)
- div_start  out  1  one-cycle pulse to div32
- div_is_signed  out  1  to div32
- div_dividend  out  XLEN  to div32, held stable from start until done
- div_divisor  out  XLEN  to div32, held stable from start until done
- div_quotient  in  XLEN  from div32
- div_remainder  in  XLEN  from div32
- div_done  in  1  from div32; level, sampled on clk

Behaviour:
- Reset values (async, rst_n low): state=IDLE; req_ready=1; rsp_valid=0; busy=0; div_start=0; div_is_signed=0; rsp_data, rsp_tag, div_dividend and div_divisor all 0.
- Reset mid-operation abandons the op with no response. div32 is reset from the same source.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready is high only in IDLE.
- On accept, latch the operands, tag, signed flag (funct3[0]==0) and rem-select (funct3[1]).
- Fast path, decided combinationally at accept:
  - rs2==0: quotient=all ones, remainder=rs1.
  - Signed, rs1=0x8000_0000 and rs2=all ones: quotient=0x8000_0000, remainder=0.
  - Transition IDLE->RESP with rsp_data loaded. rsp_valid is high on the cycle after accept (latency 1). div_start is never asserted.
- Normal path:
  - IDLE->ISSUE on accept.
  - ISSUE drives div_start=1 for exactly one cycle with operands registered, then ->WAIT.
  - In WAIT, the first sampled div_done=1 captures div_quotient or div_remainder (per rem-select) into rsp_data, then ->RESP.
  - div_done high on the cycle immediately after div_start is legal and must be honoured.
- RESP: rsp_valid=1 with rsp_data/rsp_tag stable until rsp_ready; on handshake ->IDLE. The next request is accepted no earlier than the following cycle (no back-to-back accept in the same cycle).
- flush has priority over all other events in the same cycle:
  - In ISSUE: suppress div_start, ->IDLE.
  - In WAIT: ->DRAIN, because div32 cannot be aborted. DRAIN holds busy=1 and req_ready=0 until div_done is sampled, discards the result, then ->IDLE.
  - In RESP: drop rsp_valid, ->IDLE.
  - In IDLE: any same-cycle req is not accepted.
  - In DRAIN: no effect.
- div_done outside WAIT/DRAIN is ignored.
- All outputs are registered except req_ready and busy, which decode the state.

Optional Feature:
- Macro DIV_CTRL_REUSE_EN.
- When defined:
  - Keep the last normal-path quotient and remainder with their operands and signed flag, plus a valid bit.
  - A new accept with identical rs1, rs2 and signedness and the valid bit set goes IDLE->RESP in 1 cycle using the cached value, without div_start. This makes a DIV followed by a REM on the same operands cheap.
  - The valid bit is cleared by reset, by flush in DRAIN, and on a capture that is discarded.
- When undefined: no cache storage; every non-fast-path op issues div32.

Test Plan:
- DIVU rs1=100, rs2=3 -> one div_start pulse, div_dividend=100, div_divisor=3; after div_done, rsp_data=33 with the correct rsp_tag; busy high from accept through the RESP handshake.
- REM rs1=-100, rs2=-7 -> div_is_signed=1, rsp_data=0xFFFF_FFFE (-2); DIV with the same operands -> 14.
- DIVU 1234/0 -> no div_start, rsp_valid on cycle after accept, rsp_data=0xFFFF_FFFF. REMU 1234/0 -> rsp_data=1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> no div_start, rsp_data=0x8000_0000. REM same operands -> rsp_data=0.
- flush asserted in WAIT -> DRAIN with req_ready=0 until div_done, no rsp_valid, then IDLE. Separately, hold rsp_ready=0 for 5 cycles in RESP -> rsp_data stable throughout.
- With DIV_CTRL_REUSE_EN: DIV 100/7 then REM 100/7 -> second op has no div_start and returns rsp_data=2 one cycle after accept. Without the macro, the second op issues div32.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: issue/sequencing stage in front of the div32 multi-cycle divider.
// Accepts RV32M DIV/DIVU/REM/REMU ops and resolves divide-by-zero and signed
// overflow locally. All other ops are sent to div32, and the selected result
// is returned with its rd tag.
// Optional feature: define DIV_CTRL_REUSE_EN to keep the last div32 result.
// A repeat op with the same operands is then answered without restarting div32.
module div_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             div_start,
    output logic             div_is_signed,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    input  logic             div_done
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t          state;
    logic            rem_sel;
    logic            req_signed;
    logic            req_rem;
    logic            fire;
    logic            done_ok;
    logic            fast_hit;
    logic [XLEN-1:0] fast_data;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign fire       = req_valid && req_ready && !flush;
    // Only 100/110 are signed and only 110/111 select the remainder.
    // Every other code behaves as DIVU.
    assign req_signed = req_funct3[2] & ~req_funct3[0];
    assign req_rem    = req_funct3[2] & req_funct3[1];
    // A done level seen while our start pulse is still out belongs to an older op.
    assign done_ok    = div_done && !div_start;

`ifdef DIV_CTRL_REUSE_EN
    logic            c_valid;
    logic            c_signed;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_quo;
    logic [XLEN-1:0] c_rem;

    // Result cache: filled by a delivered div32 capture, dropped when a capture is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_quo    <= '0;
            c_rem    <= '0;
        end else if (state == WAIT && !flush && done_ok) begin
            c_valid  <= 1'b1;
            c_signed <= div_is_signed;
            c_rs1    <= div_dividend;
            c_rs2    <= div_divisor;
            c_quo    <= div_quotient;
            c_rem    <= div_remainder;
        end else if (state == DRAIN && (flush || done_ok)) begin
            c_valid  <= 1'b0;
        end
    end
`endif

    // Decide at accept time whether the result is known without div32.
    always_comb begin
        fast_hit  = 1'b0;
        fast_data = '0;
        if (req_rs2 == '0) begin
            fast_hit  = 1'b1;
            fast_data = req_rem ? req_rs1 : ALL_ONES;
        end else if (req_signed && req_rs1 == MIN_NEG && req_rs2 == ALL_ONES) begin
            fast_hit  = 1'b1;
            fast_data = req_rem ? '0 : MIN_NEG;
        end
`ifdef DIV_CTRL_REUSE_EN
        else if (c_valid && req_rs1 == c_rs1 && req_rs2 == c_rs2 && req_signed == c_signed) begin
            fast_hit  = 1'b1;
            fast_data = req_rem ? c_rem : c_quo;
        end
`endif
    end

    // Sequencing FSM with registered outputs. Flush takes priority in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rem_sel       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            div_start     <= 1'b0;
            div_is_signed <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
        end else begin
            div_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        rsp_tag <= req_tag;
                        rem_sel <= req_rem;
                        if (fast_hit) begin
                            rsp_data  <= fast_data;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            div_dividend  <= req_rs1;
                            div_divisor   <= req_rs2;
                            div_is_signed <= req_signed;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        div_start <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (done_ok) begin
                        rsp_data  <= rem_sel ? div_remainder : div_quotient;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (done_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural div32 responder.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        busy;
    logic        div_start;
    logic        div_is_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    int total = 0;
    int bad = 0;

    div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy),
        .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
    );

    always #5 clk = ~clk;

    function automatic bit op_signed(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    // RV32M reference result, including the divide-by-zero and overflow rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit          sgn;
        bit          rem;
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        case (f3)
            3'b100:  begin sgn = 1; rem = 0; end
            3'b101:  begin sgn = 0; rem = 0; end
            3'b110:  begin sgn = 1; rem = 1; end
            3'b111:  begin sgn = 0; rem = 1; end
            default: begin sgn = 0; rem = 0; end
        endcase
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return rem ? r : q;
    endfunction

    // div32 responder: done after done_lat cycles, optionally left high until the next start.
    int          done_lat = 3;
    bit          done_sticky = 0;
    int          start_count = 0;
    int          m_cnt;
    bit          m_busy;
    logic [31:0] seen_a;
    logic [31:0] seen_b;
    logic        seen_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done      <= 1'b0;
            div_quotient  <= 32'd0;
            div_remainder <= 32'd0;
            m_busy        <= 1'b0;
            m_cnt         <= 0;
        end else if (div_start) begin
            start_count   <= start_count + 1;
            seen_a        <= div_dividend;
            seen_b        <= div_divisor;
            seen_s        <= div_is_signed;
            div_quotient  <= ref_div(div_is_signed ? 3'b100 : 3'b101, div_dividend, div_divisor);
            div_remainder <= ref_div(div_is_signed ? 3'b110 : 3'b111, div_dividend, div_divisor);
            if (done_lat <= 1) begin
                div_done <= 1'b1;
                m_busy   <= 1'b0;
            end else begin
                div_done <= 1'b0;
                m_busy   <= 1'b1;
                m_cnt    <= done_lat - 2;
            end
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                div_done <= 1'b1;
                m_busy   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (!done_sticky) begin
            div_done <= 1'b0;
        end
    end

    // Offer a request at a negedge and return at the negedge after it is accepted.
    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t, output bit to);
        int n = 0;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = t;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        to = !req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output bit busy_ok, output bit to);
        lat = 1;
        busy_ok = busy;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok && busy;
        end
        to = !rsp_valid;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input int hold,
                         output logic [31:0] d, output logic [4:0] rt, output int lat,
                         output int starts, output bit busy_ok, output bit to);
        int s0;
        bit to1;
        bit to2;
        s0 = start_count;
        send_req(f3, a, b, t, to1);
        wait_rsp(lat, busy_ok, to2);
        to = to1 || to2;
        d = rsp_data;
        rt = rsp_tag;
        repeat (hold) @(negedge clk);
        take_rsp();
        starts = start_count - s0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({req_ready, rsp_valid, busy, div_start, div_is_signed} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, rsp_valid, busy, div_start, div_is_signed}, 5'b10000);
        end
        total++;
        if ({rsp_data, rsp_tag, div_dividend, div_divisor} !== 101'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_data, rsp_tag, div_dividend, div_divisor);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        done_lat = 4; done_sticky = 0;
        do_op(3'b101, 32'd100, 32'd3, 5'd9, 0, d, rt, lat, st, bz, to);
        total++; if (to) begin bad++; $display("FAIL divu_timeout got=timeout exp=response"); end
        total++; if (st !== 1) begin bad++; $display("FAIL divu_starts got=%0d exp=1", st); end
        total++; if ({seen_s, seen_a, seen_b} !== {1'b0, 32'd100, 32'd3}) begin
            bad++; $display("FAIL divu_operands got=%b/%0d/%0d exp=0/100/3", seen_s, seen_a, seen_b);
        end
        total++; if (d !== 32'd33) begin bad++; $display("FAIL divu_data got=%0d exp=33", d); end
        total++; if (rt !== 5'd9) begin bad++; $display("FAIL divu_tag got=%0d exp=9", rt); end
        total++; if (!bz) begin bad++; $display("FAIL divu_busy got=low exp=high while in flight"); end
        total++; if ({busy, req_ready} !== 2'b01) begin
            bad++; $display("FAIL divu_idle got=busy%b ready%b exp=busy0 ready1", busy, req_ready);
        end
    endtask

    task automatic test_signed_rem();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        done_lat = 1; done_sticky = 1;
        do_op(3'b110, -32'sd100, -32'sd7, 5'd3, 0, d, rt, lat, st, bz, to);
        total++; if (to || d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rem_signed got=%h exp=fffffffe", d); end
        total++; if (seen_s !== 1'b1 || st !== 1) begin
            bad++; $display("FAIL rem_signed_issue got=signed%b starts%0d exp=signed1 starts1", seen_s, st);
        end
        do_op(3'b100, -32'sd100, -32'sd7, 5'd4, 0, d, rt, lat, st, bz, to);
        total++; if (to || d !== 32'd14 || rt !== 5'd4) begin
            bad++; $display("FAIL div_signed got=%0d tag%0d exp=14 tag4", d, rt);
        end
        done_sticky = 0;
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        do_op(3'b101, 32'd1234, 32'd0, 5'd5, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 0 || lat !== 1) begin
            bad++; $display("FAIL divz_path got=starts%0d lat%0d exp=starts0 lat1", st, lat);
        end
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_quot got=%h exp=ffffffff", d); end
        do_op(3'b111, 32'd1234, 32'd0, 5'd6, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 0 || d !== 32'd1234) begin
            bad++; $display("FAIL divz_rem got=%0d starts%0d exp=1234 starts0", d, st);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 0 || lat !== 1 || d !== 32'h8000_0000) begin
            bad++; $display("FAIL ovf_div got=%h starts%0d lat%0d exp=80000000 starts0 lat1", d, st, lat);
        end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 0 || d !== 32'd0) begin
            bad++; $display("FAIL ovf_rem got=%h starts%0d exp=0 starts0", d, st);
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        int n = 0;
        bit drain_ok = 1;
        bit saw_rsp = 0;
        done_lat = 6; done_sticky = 0;
        send_req(3'b101, 32'd50, 32'd5, 5'd11, to);
        while (!div_start && n < 10) begin @(negedge clk); n++; end
        total++; if (!div_start) begin bad++; $display("FAIL flushw_start got=no start exp=start pulse"); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (!div_done && n < 20) begin
            if (req_ready || !busy) drain_ok = 0;
            if (rsp_valid) saw_rsp = 1;
            @(negedge clk);
            n++;
        end
        total++; if (!drain_ok || req_ready !== 1'b0 || !div_done) begin
            bad++; $display("FAIL flushw_drain got=ready%b done%b exp=ready0 until done", req_ready, div_done);
        end
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || saw_rsp) begin
            bad++; $display("FAIL flushw_idle got=ready%b valid%b exp=ready1 valid0", req_ready, rsp_valid);
        end
        do_op(3'b101, 32'd50, 32'd5, 5'd12, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 1 || d !== 32'd10) begin
            bad++; $display("FAIL flushw_reissue got=%0d starts%0d exp=10 starts1", d, st);
        end
    endtask

    task automatic test_flush_other();
        int s0;
        int lat;
        bit bz;
        bit to;
        done_lat = 3;
        s0 = start_count;
        send_req(3'b101, 32'd90, 32'd9, 5'd13, to);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flushi_idle got=ready%b exp=ready1", req_ready); end
        repeat (3) @(negedge clk);
        total++; if (start_count !== s0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flushi_nostart got=starts%0d valid%b exp=starts0 valid0", start_count - s0, rsp_valid);
        end
        send_req(3'b111, 32'd77, 32'd0, 5'd14, to);
        wait_rsp(lat, bz, to);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL flushr_drop got=valid%b ready%b exp=valid0 ready1", rsp_valid, req_ready);
        end
        req_valid = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd8; req_rs2 = 32'd0; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_idle_req got=busy%b valid%b exp=busy0 valid0", busy, rsp_valid);
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] exp;
        int lat;
        bit bz;
        bit to;
        bit stable = 1;
        done_lat = 2;
        exp = ref_div(3'b100, 32'd1000, -32'sd3);
        send_req(3'b100, 32'd1000, -32'sd3, 5'd21, to);
        wait_rsp(lat, bz, to);
        repeat (5) begin
            if (!rsp_valid || rsp_data !== exp || rsp_tag !== 5'd21) stable = 0;
            @(negedge clk);
        end
        total++; if (to || !stable || rsp_data !== exp) begin
            bad++; $display("FAIL resp_hold got=%h valid%b exp=%h held", rsp_data, rsp_valid, exp);
        end
        take_rsp();
    endtask

    task automatic test_reuse();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        done_lat = 3;
        do_op(3'b100, 32'd100, 32'd7, 5'd15, 0, d, rt, lat, st, bz, to);
        total++; if (to || st !== 1 || d !== 32'd14) begin
            bad++; $display("FAIL reuse_first got=%0d starts%0d exp=14 starts1", d, st);
        end
        do_op(3'b110, 32'd100, 32'd7, 5'd16, 0, d, rt, lat, st, bz, to);
        total++; if (to || d !== 32'd2 || rt !== 5'd16) begin
            bad++; $display("FAIL reuse_data got=%0d tag%0d exp=2 tag16", d, rt);
        end
`ifdef DIV_CTRL_REUSE_EN
        total++; if (st !== 0 || lat !== 1) begin
            bad++; $display("FAIL reuse_hit got=starts%0d lat%0d exp=starts0 lat1", st, lat);
        end
`else
        total++; if (st !== 1) begin bad++; $display("FAIL reuse_issue got=starts%0d exp=starts1", st); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] d; logic [4:0] rt; int lat; int st; bit bz; bit to;
        logic [31:0] a = 32'd1;
        logic [31:0] b = 32'd1;
        logic [2:0]  f3;
        logic [4:0]  t;
        bit          fast;
        for (int i = 0; i < 60; i++) begin
            done_lat = int'($urandom_range(1, 5));
            done_sticky = ($urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: a = $urandom;
                    1: a = 32'h8000_0000;
                    2: a = 32'($urandom_range(0, 200));
                    default: a = -32'($urandom_range(1, 200));
                endcase
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = $urandom;
                    default: b = 32'($urandom_range(0, 20));
                endcase
            end
            fast = (b == 32'd0) || (op_signed(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            do_op(f3, a, b, t, int'($urandom_range(0, 2)), d, rt, lat, st, bz, to);
            total++;
            if (to || d !== ref_div(f3, a, b) || rt !== t) begin
                bad++;
                $display("FAIL rand_%0d got=%h tag%0d exp=%h tag%0d (f3=%b a=%h b=%h)",
                         i, d, rt, ref_div(f3, a, b), t, f3, a, b);
            end
            if (fast) begin
                total++;
                if (st !== 0 || lat !== 1) begin
                    bad++; $display("FAIL rand_fast_%0d got=starts%0d lat%0d exp=starts0 lat1", i, st, lat);
                end
            end
`ifndef DIV_CTRL_REUSE_EN
            else begin
                total++;
                if (st !== 1) begin bad++; $display("FAIL rand_issue_%0d got=starts%0d exp=starts1", i, st); end
            end
`endif
        end
        done_sticky = 0;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed_rem();
        test_div_by_zero();
        test_overflow();
        test_flush_wait();
        test_flush_other();
        test_resp_hold();
        test_reuse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
